// File: rtl/regbus_pkg.sv
// Shared sizing constants and sequencer state type for the register-bus controller.
package regbus_pkg;

   localparam int XLEN  = 32;
   localparam int NREGS = 32;

   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int IDX_W = idx_width(NREGS);

   typedef enum logic [1:0] {
      IDLE,
      DRIVE,
      WRITE,
      RESP
   } state_t;

endpackage

// File: rtl/regbus_onehot_dec.sv
// Index to one-hot decoder; index 0 and indices past NOUT-1 decode to all-zero.
module regbus_onehot_dec
   import regbus_pkg::*;
#(
   parameter int NOUT = NREGS,
   parameter int IW   = IDX_W
) (
   input  logic [IW-1:0]   idx,
   input  logic            en,
   output logic [NOUT-1:0] onehot
);

   always_comb begin
      // NOTE: every bit gets a default first so this stays combinational (no latch).
      onehot = '0;
      for (int i = 1; i < NOUT; i++) begin
         if (en && (idx == IW'(i))) onehot[i] = 1'b1;
      end
   end

endmodule

// File: rtl/regbus_ctrl.sv
// Register-bus sequencer: drives the shared A/B buses for one cycle, strobes the
// write-back register, then holds the captured operands until the response is taken.
module regbus_ctrl
   import regbus_pkg::*;
#(
   parameter int  XLEN  = regbus_pkg::XLEN,
   parameter int  NREGS = regbus_pkg::NREGS,
   localparam int IW    = idx_width(NREGS)
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [IW-1:0]    req_rs1,
   input  logic [IW-1:0]    req_rs2,
   input  logic [IW-1:0]    req_rd,
   input  logic             req_we,
   input  logic [XLEN-1:0]  req_wdata,
   output logic [NREGS-1:0] enable_a,
   output logic [NREGS-1:0] enable_b,
   output logic [NREGS-1:0] store,
   output logic [XLEN-1:0]  data,
   input  logic [XLEN-1:0]  a_bus,
   input  logic [XLEN-1:0]  b_bus,
   output logic             resp_valid,
   input  logic             resp_ready,
   output logic [XLEN-1:0]  resp_a,
   output logic [XLEN-1:0]  resp_b
);

   state_t            state;
   logic [IW-1:0]     rs1_q;
   logic [IW-1:0]     rs2_q;
   logic [IW-1:0]     rd_q;
   logic              we_q;
   logic [XLEN-1:0]   wdata_q;
   logic              accept;
   logic              rs1_live;
   logic              rs2_live;
   logic [NREGS-1:0]  dec_a;
   logic [NREGS-1:0]  dec_b;
   logic [NREGS-1:0]  dec_st;

   assign accept   = (state == IDLE) && req_valid;
   assign rs1_live = (rs1_q != '0) && (int'(rs1_q) < NREGS);
   assign rs2_live = (rs2_q != '0) && (int'(rs2_q) < NREGS);

   // Strobes are decoded one cycle early and registered, so the outputs are flops.
   regbus_onehot_dec #(.NOUT(NREGS), .IW(IW)) u_dec_a (
      .idx    (req_rs1),
      .en     (accept),
      .onehot (dec_a)
   );

   regbus_onehot_dec #(.NOUT(NREGS), .IW(IW)) u_dec_b (
      .idx    (req_rs2),
      .en     (accept),
      .onehot (dec_b)
   );

   regbus_onehot_dec #(.NOUT(NREGS), .IW(IW)) u_dec_st (
      .idx    (rd_q),
      .en     ((state == DRIVE) && we_q),
      .onehot (dec_st)
   );

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         req_ready  <= 1'b1;
         rs1_q      <= '0;
         rs2_q      <= '0;
         rd_q       <= '0;
         we_q       <= 1'b0;
         wdata_q    <= '0;
         enable_a   <= '0;
         enable_b   <= '0;
         store      <= '0;
         data       <= '0;
         resp_valid <= 1'b0;
         resp_a     <= '0;
         resp_b     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  rs1_q     <= req_rs1;
                  rs2_q     <= req_rs2;
                  rd_q      <= req_rd;
                  we_q      <= req_we;
                  wdata_q   <= req_wdata;
                  enable_a  <= dec_a;
                  enable_b  <= dec_b;
                  req_ready <= 1'b0;
                  state     <= DRIVE;
               end
            end
            DRIVE: begin
               // An undriven bus is never sampled; index 0 reads as zero.
               enable_a <= '0;
               enable_b <= '0;
               resp_a   <= rs1_live ? a_bus : '0;
               resp_b   <= rs2_live ? b_bus : '0;
               store    <= dec_st;
               data     <= wdata_q;
               state    <= WRITE;
            end
            WRITE: begin
               store      <= '0;
               data       <= '0;
               resp_valid <= 1'b1;
               state      <= RESP;
            end
            RESP: begin
               if (resp_ready) begin
                  resp_valid <= 1'b0;
                  req_ready  <= 1'b1;
                  state      <= IDLE;
               end
            end
            default: begin
               enable_a   <= '0;
               enable_b   <= '0;
               store      <= '0;
               data       <= '0;
               resp_valid <= 1'b0;
               req_ready  <= 1'b1;
               state      <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_regbus_ctrl.sv
// Bench for regbus_ctrl: register instances on shared buses, a transaction-level
// reference model checked every cycle, and directed scenarios with literal results.
module tb_regbus_ctrl;

   localparam int XLEN  = 32;
   localparam int NREGS = 32;
   localparam int IW    = 5;
   localparam logic [XLEN-1:0] FLOAT = 32'hF10A_7F10;

   logic             clk        = 1'b0;
   logic             reset_n    = 1'b1;
   logic             req_valid  = 1'b0;
   logic             req_ready;
   logic [IW-1:0]    req_rs1    = '0;
   logic [IW-1:0]    req_rs2    = '0;
   logic [IW-1:0]    req_rd     = '0;
   logic             req_we     = 1'b0;
   logic [XLEN-1:0]  req_wdata  = '0;
   logic [NREGS-1:0] enable_a;
   logic [NREGS-1:0] enable_b;
   logic [NREGS-1:0] store;
   logic [XLEN-1:0]  data;
   logic [XLEN-1:0]  a_bus;
   logic [XLEN-1:0]  b_bus;
   logic             resp_valid;
   logic             resp_ready = 1'b1;
   logic [XLEN-1:0]  resp_a;
   logic [XLEN-1:0]  resp_b;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   regbus_ctrl #(.XLEN(XLEN), .NREGS(NREGS)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_rs1    (req_rs1),
      .req_rs2    (req_rs2),
      .req_rd     (req_rd),
      .req_we     (req_we),
      .req_wdata  (req_wdata),
      .enable_a   (enable_a),
      .enable_b   (enable_b),
      .store      (store),
      .data       (data),
      .a_bus      (a_bus),
      .b_bus      (b_bus),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_a     (resp_a),
      .resp_b     (resp_b)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Register instances: x0 holds junk so any drive of x0 onto a bus is visible.
   logic [XLEN-1:0] regs [NREGS] = '{0: 32'h5A5A_5A5A, default: '0};

   always @(posedge clk) begin
      for (int i = 0; i < NREGS; i++) begin
         if (store[i]) regs[i] <= data;
      end
   end

   // Shared buses: an undriven bus reads as FLOAT; contention ANDs the drivers.
   int a_drv;
   int b_drv;
   always_comb begin
      a_bus = FLOAT;
      b_bus = FLOAT;
      a_drv = 0;
      b_drv = 0;
      for (int i = 0; i < NREGS; i++) begin
         if (enable_a[i]) begin
            a_bus = (a_drv == 0) ? regs[i] : (a_bus & regs[i]);
            a_drv++;
         end
         if (enable_b[i]) begin
            b_bus = (b_drv == 0) ? regs[i] : (b_bus & regs[i]);
            b_drv++;
         end
      end
   end

   // Architectural reference: register file plus a transaction timeline.
   logic [XLEN-1:0] mdl [NREGS] = '{default: '0};
   int              phase = 0;
   logic [IW-1:0]   t_rs1, t_rs2, t_rd;
   logic            t_we;
   logic [XLEN-1:0] t_wd, exp_a, exp_b;
   logic            commit_pending = 1'b0;

   function automatic logic [NREGS-1:0] oh(input logic [IW-1:0] idx);
      logic [NREGS-1:0] v;
      v = '0;
      if (idx != '0 && int'(idx) < NREGS) v[idx] = 1'b1;
      return v;
   endfunction

   function automatic logic [XLEN-1:0] rd_val(input logic [IW-1:0] idx);
      if (idx == '0 || int'(idx) >= NREGS) return '0;
      return mdl[idx];
   endfunction

   always @(negedge clk or negedge reset_n) begin
      if (!reset_n) begin
         phase          = 0;
         commit_pending = 1'b0;
      end else begin
         if (commit_pending) begin
            if (t_we && t_rd != '0) mdl[t_rd] = t_wd;
            commit_pending = 1'b0;
         end
         check("req_ready",  64'(req_ready),  64'(phase == 0));
         check("resp_valid", 64'(resp_valid), 64'(phase == 3));
         check("enable_a",   64'(enable_a),   64'((phase == 1) ? oh(t_rs1) : '0));
         check("enable_b",   64'(enable_b),   64'((phase == 1) ? oh(t_rs2) : '0));
         check("store",      64'(store),      64'((phase == 2 && t_we) ? oh(t_rd) : '0));
         check("data",       64'(data),       64'((phase == 2) ? t_wd : '0));
         check("onehot_a",   64'($countones(enable_a) <= 1), 64'd1);
         check("onehot_b",   64'($countones(enable_b) <= 1), 64'd1);
         check("onehot_st",  64'($countones(store) <= 1),    64'd1);
         check("a_drivers",  64'(a_drv <= 1), 64'd1);
         check("b_drivers",  64'(b_drv <= 1), 64'd1);
         if (phase == 3) begin
            check("resp_a", 64'(resp_a), 64'(exp_a));
            check("resp_b", 64'(resp_b), 64'(exp_b));
         end
         case (phase)
            0: if (req_valid) begin
               t_rs1 = req_rs1;
               t_rs2 = req_rs2;
               t_rd  = req_rd;
               t_we  = req_we;
               t_wd  = req_wdata;
               exp_a = rd_val(req_rs1);
               exp_b = rd_val(req_rs2);
               phase = 1;
            end
            1: phase = 2;
            2: begin
               phase          = 3;
               commit_pending = 1'b1;
            end
            default: if (resp_ready) phase = 0;
         endcase
      end
   end

   // One request/response; hold>0 keeps resp_ready low for that many RESP edges.
   task automatic do_req(input logic [IW-1:0] rs1, input logic [IW-1:0] rs2,
                         input logic [IW-1:0] rd, input logic we,
                         input logic [XLEN-1:0] wd, input int hold,
                         output logic [XLEN-1:0] ra, output logic [XLEN-1:0] rb);
      int n;
      @(posedge clk);
      #1;
      req_rs1    = rs1;
      req_rs2    = rs2;
      req_rd     = rd;
      req_we     = we;
      req_wdata  = wd;
      req_valid  = 1'b1;
      resp_ready = (hold == 0);
      n = 0;
      @(negedge clk);
      while (!req_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("accept_in_time", 64'(req_ready), 64'd1);
      @(posedge clk);
      #1 req_valid = 1'b0;
      n = 0;
      @(negedge clk);
      while (!resp_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("resp_in_time", 64'(resp_valid), 64'd1);
      if (hold > 0) begin
         repeat (hold) @(posedge clk);
         #1 resp_ready = 1'b1;
         @(negedge clk);
      end
      ra = resp_a;
      rb = resp_b;
      @(posedge clk);
      #1 resp_ready = 1'b1;
   endtask

   initial begin
      logic [XLEN-1:0] ra, rb;
      int n;
      #3 reset_n = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_resp_a",     64'(resp_a),     64'd0);
      check("rst_resp_b",     64'(resp_b),     64'd0);
      check("rst_resp_valid", 64'(resp_valid), 64'd0);
      check("rst_store",      64'(store),      64'd0);
      check("rst_data",       64'(data),       64'd0);
      #2 reset_n = 1'b1;
      @(negedge clk);
      check("ready_after_rst", 64'(req_ready), 64'd1);

      // Write x5, then read it back on A with x0 on B.
      do_req(5'd0, 5'd0, 5'd5, 1'b1, 32'hDEAD_BEEF, 0, ra, rb);
      check("x5_stored", 64'(regs[5]), 64'hDEAD_BEEF);
      do_req(5'd5, 5'd0, 5'd0, 1'b0, 32'h0, 0, ra, rb);
      check("rd_x5_a", 64'(ra), 64'hDEAD_BEEF);
      check("rd_x5_b", 64'(rb), 64'd0);

      // Read-before-write with rs1 = rs2 = rd.
      do_req(5'd0, 5'd0, 5'd3, 1'b1, 32'h11, 0, ra, rb);
      do_req(5'd3, 5'd3, 5'd3, 1'b1, 32'h22, 0, ra, rb);
      check("rbw_a", 64'(ra), 64'h11);
      check("rbw_b", 64'(rb), 64'h11);
      do_req(5'd3, 5'd0, 5'd0, 1'b0, 32'h0, 0, ra, rb);
      check("x3_new", 64'(ra), 64'h22);

      // Writes to x0 are dropped; x0 reads as zero.
      do_req(5'd0, 5'd0, 5'd0, 1'b1, 32'hFFFF_FFFF, 0, ra, rb);
      do_req(5'd0, 5'd0, 5'd0, 1'b0, 32'h0, 0, ra, rb);
      check("x0_a", 64'(ra), 64'd0);
      check("x0_b", 64'(rb), 64'd0);
      check("x0_untouched", 64'(regs[0]), 64'h5A5A_5A5A);

      // Response back-pressure for 5 cycles.
      do_req(5'd5, 5'd3, 5'd7, 1'b1, 32'h77, 5, ra, rb);
      check("hold_a", 64'(ra), 64'hDEAD_BEEF);
      check("hold_b", 64'(rb), 64'h22);
      do_req(5'd7, 5'd0, 5'd0, 1'b0, 32'h0, 0, ra, rb);
      check("x7_new", 64'(ra), 64'h77);

      // Reset asserted while the store strobe is high.
      @(posedge clk);
      #1;
      req_rs1   = 5'd5;
      req_rs2   = 5'd0;
      req_rd    = 5'd5;
      req_we    = 1'b1;
      req_wdata = 32'hCAFE_F00D;
      req_valid = 1'b1;
      @(posedge clk);
      #1 req_valid = 1'b0;
      n = 0;
      @(negedge clk);
      while (store[5] !== 1'b1 && n < 5) begin
         @(negedge clk);
         n++;
      end
      check("abort_store_seen", 64'(store[5]), 64'd1);
      #1 reset_n = 1'b0;
      #1;
      check("abort_store_drop", 64'(store), 64'd0);
      check("abort_data_drop",  64'(data),  64'd0);
      repeat (2) @(posedge clk);
      #1;
      check("abort_no_resp", 64'(resp_valid), 64'd0);
      check("abort_keep_x5", 64'(regs[5]), 64'hDEAD_BEEF);
      reset_n = 1'b1;
      do_req(5'd5, 5'd0, 5'd0, 1'b0, 32'h0, 0, ra, rb);
      check("x5_after_abort", 64'(ra), 64'hDEAD_BEEF);

      // A short sweep of distinct registers on both buses.
      for (int i = 8; i < 12; i++) begin
         do_req(5'd0, 5'd0, IW'(i), 1'b1, 32'(i) * 32'h0101_0101, 0, ra, rb);
      end
      for (int i = 8; i < 12; i++) begin
         do_req(IW'(i), IW'(19 - i), 5'd0, 1'b0, 32'h0, 0, ra, rb);
         check("sweep_a", 64'(ra), 64'(32'(i) * 32'h0101_0101));
         check("sweep_b", 64'(rb), 64'(32'(19 - i) * 32'h0101_0101));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL watchdog: simulation did not reach its end, got timeout, expected completion");
      $fatal(1);
   end

endmodule
